enemy_hit_scheduler: RTL and testbench

ENEMY_HIT_SCHEDULER -- requirements
Module: enemy_hit_scheduler

---
 rtl/enemy_hit_scheduler.sv | 164 ++++++++++++++++
 tb/tb_enemy_hit_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/enemy_hit_scheduler.sv
// Time-multiplexed enemy/bullet collision scheduler: one shared comparator walks all pairs per frame.
// Optional sticky overrun flag is built only when ENEMY_HIT_SCHED_OVERRUN_EN is defined.
module enemy_hit_scheduler #(
  parameter int         N_ENEMY     = 4,
  parameter int         N_BULLET    = 4,
  parameter logic [2:0] HEALTH_INIT = 3'd3,
  parameter int         Y_OFFSET    = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [10*N_ENEMY-1:0]   ep_x,
  input  logic [10*N_ENEMY-1:0]   ep_y,
  input  logic [10*N_BULLET-1:0]  b_x,
  input  logic [10*N_BULLET-1:0]  b_y,
  input  logic [N_ENEMY-1:0]      enemy_en,
  input  logic [N_BULLET-1:0]     bullet_en,
  input  logic [N_ENEMY-1:0]      enemy_respawn,
  output logic [N_BULLET-1:0]     bullet_kill,
  output logic [N_ENEMY-1:0]      enemy_hit,
  output logic [N_ENEMY-1:0]      enemy_boom,
  output logic                    scan_busy,
  output logic                    scan_done,
  output logic                    scan_overrun
);

  localparam int EW = (N_ENEMY  > 1) ? $clog2(N_ENEMY)  : 1;
  localparam int BW = (N_BULLET > 1) ? $clog2(N_BULLET) : 1;
  localparam logic [EW-1:0] E_LAST = EW'(N_ENEMY - 1);
  localparam logic [BW-1:0] B_LAST = BW'(N_BULLET - 1);
  localparam logic [11:0]   Y_OFF  = 12'(Y_OFFSET);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e state_q, state_d;

  logic [9:0]          ex_q [N_ENEMY];
  logic [9:0]          ey_q [N_ENEMY];
  logic [9:0]          bx_q [N_BULLET];
  logic [9:0]          by_q [N_BULLET];
  logic [2:0]          health_q [N_ENEMY];
  logic [N_ENEMY-1:0]  een_q;
  logic [N_BULLET-1:0] ben_q;
  logic [N_BULLET-1:0] used_q;
  logic [EW-1:0]       e_idx_q;
  logic [BW-1:0]       b_idx_q;
  logic [N_BULLET-1:0] kill_q;
  logic [N_ENEMY-1:0]  hit_q;
  logic [N_ENEMY-1:0]  boom_q;

  logic [11:0] ex_c, ey_c, bx_c, by_c;
  logic        geom_hit, qual, last_pair;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = SCAN;
      SCAN:    if (last_pair)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shared comparator: all operands widened to 12 bits so the +offset/+box terms never wrap.
  assign ex_c = {2'b00, ex_q[e_idx_q]};
  assign ey_c = {2'b00, ey_q[e_idx_q]} + Y_OFF;
  assign bx_c = {2'b00, bx_q[b_idx_q]};
  assign by_c = {2'b00, by_q[b_idx_q]};

  assign geom_hit = (ex_c + 12'd10 >= bx_c) && (ex_c < bx_c + 12'd50) &&
                    (ey_c + 12'd50 >= by_c) && (ey_c < by_c + 12'd40);

  assign qual = (state_q == SCAN) && geom_hit &&
                een_q[e_idx_q] && (health_q[e_idx_q] != 3'd0) &&
                ben_q[b_idx_q] && !used_q[b_idx_q];

  assign last_pair = (state_q == SCAN) && (e_idx_q == E_LAST) && (b_idx_q == B_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < N_ENEMY; e++) begin
        ex_q[e]     <= '0;
        ey_q[e]     <= '0;
        health_q[e] <= HEALTH_INIT;
      end
      for (int b = 0; b < N_BULLET; b++) begin
        bx_q[b] <= '0;
        by_q[b] <= '0;
      end
      een_q   <= '0;
      ben_q   <= '0;
      used_q  <= '0;
      e_idx_q <= '0;
      b_idx_q <= '0;
      kill_q  <= '0;
      hit_q   <= '0;
      boom_q  <= '0;
    end else begin
      kill_q <= '0;
      hit_q  <= '0;
      if (state_q == IDLE && frame_start) begin
        for (int e = 0; e < N_ENEMY; e++) begin
          ex_q[e] <= ep_x[10*e +: 10];
          ey_q[e] <= ep_y[10*e +: 10];
        end
        for (int b = 0; b < N_BULLET; b++) begin
          bx_q[b] <= b_x[10*b +: 10];
          by_q[b] <= b_y[10*b +: 10];
        end
        een_q   <= enemy_en;
        ben_q   <= bullet_en;
        used_q  <= '0;
        e_idx_q <= '0;
        b_idx_q <= '0;
      end else if (state_q == SCAN) begin
        if (b_idx_q == B_LAST) begin
          b_idx_q <= '0;
          e_idx_q <= e_idx_q + 1'b1;
        end else begin
          b_idx_q <= b_idx_q + 1'b1;
        end
        if (qual) begin
          used_q[b_idx_q] <= 1'b1;
          kill_q[b_idx_q] <= 1'b1;
        end
      end
      // Respawn overrides a same-cycle decrement and swallows its hit pulse.
      for (int e = 0; e < N_ENEMY; e++) begin
        if (enemy_respawn[e]) begin
          health_q[e] <= HEALTH_INIT;
        end else if (qual && (e_idx_q == EW'(e))) begin
          health_q[e] <= health_q[e] - 3'd1;
          hit_q[e]    <= 1'b1;
        end
        boom_q[e] <= (health_q[e] == 3'd0);
      end
    end
  end

`ifdef ENEMY_HIT_SCHED_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              overrun_q <= 1'b0;
    else if (frame_start && state_q != IDLE) overrun_q <= 1'b1;
  end

  assign scan_overrun = overrun_q;
`else
  assign scan_overrun = 1'b0;
`endif

  assign bullet_kill = kill_q;
  assign enemy_hit   = hit_q;
  assign enemy_boom  = boom_q;
  assign scan_busy   = (state_q == SCAN);
  assign scan_done   = (state_q == DONE);

endmodule

// File: tb/tb_enemy_hit_scheduler.sv
// Scoreboard bench for enemy_hit_scheduler: stimulus pushes expected pulses, a monitor pops and compares.
module tb_enemy_hit_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [39:0] ep_x, ep_y, b_x, b_y;
  logic [3:0]  enemy_en, bullet_en, enemy_respawn;
  logic [3:0]  bullet_kill, enemy_hit, enemy_boom;
  logic        scan_busy, scan_done, scan_overrun;

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;
  logic [7:0] exp_q[$];

  enemy_hit_scheduler dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .ep_x(ep_x), .ep_y(ep_y), .b_x(b_x), .b_y(b_y),
    .enemy_en(enemy_en), .bullet_en(bullet_en), .enemy_respawn(enemy_respawn),
    .bullet_kill(bullet_kill), .enemy_hit(enemy_hit), .enemy_boom(enemy_boom),
    .scan_busy(scan_busy), .scan_done(scan_done), .scan_overrun(scan_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_enemy(input int e, input int x, input int y, input bit en);
    ep_x[10*e +: 10] = 10'(x);
    ep_y[10*e +: 10] = 10'(y);
    enemy_en[e] = en;
  endtask

  task automatic set_bullet(input int b, input int x, input int y, input bit en);
    b_x[10*b +: 10] = 10'(x);
    b_y[10*b +: 10] = 10'(y);
    bullet_en[b] = en;
  endtask

  task automatic respawn(input logic [3:0] m);
    @(negedge clk) enemy_respawn = m;
    @(negedge clk) enemy_respawn = '0;
    repeat (2) @(negedge clk);
  endtask

  // rsp: respawn enemy0 on the edge that lands pair (0,0); mid: re-pulse frame_start mid-scan.
  task automatic run_frame(input bit rsp, input int mid);
    int n;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    if (rsp) enemy_respawn = 4'b0001;
    n = 1;
    while (n < 100) begin
      if (scan_done) break;
      @(negedge clk);
      enemy_respawn = '0;
      n++;
      frame_start = (mid != 0 && n == mid);
    end
    frame_start = 1'b0;
    chk("frame_latency", n, 17);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (scan_busy) busy_cnt++;
      if (bullet_kill != 4'b0 || enemy_hit != 4'b0) begin
        if (exp_q.size() == 0) begin
          chk("pulse_unexpected", {24'b0, bullet_kill, enemy_hit}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kill", bullet_kill, e[7:4]);
          chk("pulse_hit", enemy_hit, e[3:0]);
        end
      end
      if (scan_done) begin
        chk("scan_len", busy_cnt, 16);
        busy_cnt = 0;
      end
    end
  end

  initial begin
    rst = 1'b0; frame_start = 1'b0;
    ep_x = '0; ep_y = '0; b_x = '0; b_y = '0;
    enemy_en = '0; bullet_en = '0; enemy_respawn = '0;
    for (int i = 0; i < 4; i++) begin
      set_enemy(i, 0, 0, 1'b0);
      set_bullet(i, 900, 0, 1'b0);
    end
    repeat (3) @(negedge clk);
    chk("rst_kill", bullet_kill, 0);
    chk("rst_hit", enemy_hit, 0);
    chk("rst_boom", enemy_boom, 0);
    chk("rst_busy", scan_busy, 0);
    chk("rst_done", scan_done, 0);
    chk("rst_overrun", scan_overrun, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single overlap, three frames to drain health, fourth frame silent.
    set_enemy(0, 100, 0, 1'b1);
    set_bullet(0, 100, 480, 1'b1);
    exp_q.push_back({4'b0001, 4'b0001}); run_frame(0, 0);
    chk("boom_h2", enemy_boom, 4'b0000);
    exp_q.push_back({4'b0001, 4'b0001}); run_frame(0, 0);
    chk("boom_h1", enemy_boom, 4'b0000);
    exp_q.push_back({4'b0001, 4'b0001}); run_frame(0, 0);
    chk("boom_h0", enemy_boom, 4'b0001);
    run_frame(0, 0);
    chk("boom_dead_frame", enemy_boom, 4'b0001);
    respawn(4'b0001);
    chk("boom_respawn", enemy_boom, 4'b0000);

    // One bullet overlapping two enemies: lower enemy index takes it.
    set_enemy(1, 120, 0, 1'b1);
    exp_q.push_back({4'b0001, 4'b0001}); run_frame(0, 0);

    // Three bullets into enemy0; bullet3 overlaps but is disabled.
    respawn(4'b1111);
    set_enemy(1, 120, 0, 1'b0);
    set_bullet(1, 110, 480, 1'b1);
    set_bullet(2, 95, 490, 1'b1);
    set_bullet(3, 100, 480, 1'b0);
    exp_q.push_back({4'b0001, 4'b0001});
    exp_q.push_back({4'b0010, 4'b0001});
    exp_q.push_back({4'b0100, 4'b0001});
    run_frame(0, 0);
    chk("boom_triple", enemy_boom, 4'b0001);

    // Edges: e0 at bx+50 misses, e1 at ex+10==bx hits, e2 at ey'==by+40 misses.
    respawn(4'b1111);
    set_enemy(0, 150, 0, 1'b1);
    set_enemy(1, 90, 0, 1'b1);
    set_enemy(2, 300, 0, 1'b1);
    set_bullet(0, 100, 480, 1'b1);
    set_bullet(1, 100, 480, 1'b1);
    set_bullet(2, 300, 440, 1'b1);
    exp_q.push_back({4'b0001, 4'b0010});
    exp_q.push_back({4'b0010, 4'b0010});
    run_frame(0, 0);
    chk("boom_boundary", enemy_boom, 4'b0000);
    chk("overrun_before", scan_overrun, 0);

    // frame_start mid-scan is dropped.
    respawn(4'b1111);
    set_enemy(0, 100, 0, 1'b1);
    set_enemy(1, 0, 0, 1'b0);
    set_enemy(2, 0, 0, 1'b0);
    set_bullet(1, 900, 0, 1'b0);
    set_bullet(2, 900, 0, 1'b0);
    exp_q.push_back({4'b0001, 4'b0001}); run_frame(0, 5);
    repeat (20) @(negedge clk);
    chk("no_queued_scan", scan_busy, 0);
`ifdef ENEMY_HIT_SCHED_OVERRUN_EN
    chk("overrun_set", scan_overrun, 1);
`else
    chk("overrun_tied", scan_overrun, 0);
`endif

    // Respawn on the decrement edge: kill still fires, hit suppressed, health back to 3.
    exp_q.push_back({4'b0001, 4'b0000}); run_frame(1, 0);
    exp_q.push_back({4'b0001, 4'b0001}); run_frame(0, 0);
    exp_q.push_back({4'b0001, 4'b0001}); run_frame(0, 0);
    chk("boom_after_rsp_h1", enemy_boom, 4'b0000);
    exp_q.push_back({4'b0001, 4'b0001}); run_frame(0, 0);
    chk("boom_after_rsp_h0", enemy_boom, 4'b0001);

    repeat (3) @(negedge clk);
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
